belt_sort_sequencer: RTL and testbench
======================================

// Module: belt_sort_sequencer
// PURPOSE
//  Top-level sequencer for the sorting conveyor. Drives the belt stepper's one-cycle ON_belt/OFF_belt
//  pulses, stops the belt when the item sensor fires, and waits for a material classification.
//  Then issues a req/done handshake to the diverter (flap) driver for the chosen bin and restarts the belt.
//  Sits between the sensor/classifier front-end and the belt + diverter stepper drivers.
// PARAMETERS
//  DEBOUNCE_CYC   16'd50000        item_present must be stable this many clk to be accepted (1 ms @ 50 MHz)
//  SETTLE_CYC     32'd5000000      belt-stopped dwell before classification is sampled (100 ms)
//  CLASSIFY_TO    32'd25000000     max wait for material_valid in CLASSIFY (500 ms)
//  SORT_TO        32'd100000000    max wait for sort_done after sort_req (2 s)
//  CLEAR_TO       32'd150000000    max wait for debounced sensor to drop after restart (3 s)
//  DEFAULT_BIN    2'd3             bin used when classification is unknown/times out
// PORTS
//  clk            in   1   system clock, 50 MHz
//  rst_n          in   1   asynchronous active-low reset
//  start          in   1   level/pulse; starts sorting from IDLE
//  stop           in   1   level/pulse; stops belt, returns to IDLE from any state
//  item_present   in   1   raw item sensor (async), active high
//  material       in   2   classifier result: 0 metal, 1 plastic, 2 paper, 3 unknown
//  material_valid in   1   1-cycle strobe qualifying material
//  sort_done      in   1   diverter finished positioning/ejecting (level or pulse)
//  belt_on        out  1   1-cycle pulse to belt stepper ON input
//  belt_off       out  1   1-cycle pulse to belt stepper OFF input
//  sort_req       out  1   held high until sort_done seen
//  sort_bin       out  2   bin code, stable while sort_req high
//  busy           out  1   high in every state except IDLE and FAULT
//  fault          out  1   sticky timeout flag
//  fault_code     out  2   1 clear timeout, 2 sort timeout, 0 none (classify timeout is not a fault)
//  item_count     out  16  total items sorted, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. item_present passes a 2-FF synchroniser, then debounce.
//  States: IDLE, RUN, SETTLE, CLASSIFY, SORT, CLEAR, FAULT.
//  IDLE: start=1 -> belt_on pulse, RUN.
//  RUN: debounced sensor rising -> belt_off pulse, timer clear, SETTLE.
//  SETTLE: timer == SETTLE_CYC-1 -> CLASSIFY. material_valid here is ignored.
//  CLASSIFY: material_valid -> latch bin (3 -> DEFAULT_BIN), SORT. timeout -> bin=DEFAULT_BIN, SORT.
//  SORT: sort_req=1 from entry cycle; sort_done -> sort_req=0 next cycle, item_count+1,
//        belt_on pulse, CLEAR. timeout -> FAULT, code 2.
//  CLEAR: debounced sensor low -> RUN. timeout -> belt_off pulse, FAULT, code 1.
//  FAULT: belt stopped, sort_req=0; only stop exits (-> IDLE, fault and code cleared); start ignored.
//  stop: highest priority; from RUN/CLEAR emits belt_off pulse; from any state -> IDLE, sort_req=0,
//   timers cleared. start and stop same cycle: stop wins, no belt_on.
//  One shared 32-bit timer, cleared on every state entry; all timeouts compare with ==PARAM-1.
//  belt_on and belt_off never assert in the same cycle.
//  Each pulse is exactly 1 clk wide. An item still present at start is not re-detected until
//   the sensor falls and rises again (edge-based).
//  rst_n mid-operation: immediate return to reset values. No belt_off is emitted; the belt driver is reset by the same rst_n.
// STRUCTURE
//  Shared package sort_pkg: state encoding, material/bin codes, fault_code values.
//  Sub-module: sensor_debounce (2-FF sync + stable counter + rising/falling edge strobes).
//   Instantiated once.
//  Sequencer FSM, timer and item counter live in this module.
// TESTING (use DEBOUNCE_CYC=4, SETTLE_CYC=10, CLASSIFY_TO=20, SORT_TO=30, CLEAR_TO=40)
//  Normal item: start; sensor high 8 clk; material=1 strobe; sort_done after 5 clk.
//   Expect belt_off, then sort_req/bin=1; then belt_on, item_count=1, RUN after sensor drop.
//  Glitch: sensor high 2 clk in RUN -> no belt_off, state stays RUN.
//  Classify timeout: no material_valid -> sort_bin=3 exactly 20 clk after CLASSIFY entry, fault=0.
//  Sort timeout: never assert sort_done -> fault=1, code=2 at 30 clk. start ignored; stop -> IDLE, fault=0.
//  Stop mid-SETTLE, and start+stop same cycle in IDLE.
//   Expect IDLE, sort_req=0, no belt_on pulse; in RUN, stop gives exactly one belt_off.
//  Async reset asserted in SORT -> sort_req, busy, item_count = 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/sort_pkg.sv
// -----------------------------------------------------------------------------
// sort_pkg
// Shared definitions for the sorting conveyor sequencer: FSM state encoding,
// material/bin codes, fault codes and the material-to-bin mapping helper.
// -----------------------------------------------------------------------------
package sort_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_SETTLE,
        ST_CLASSIFY,
        ST_SORT,
        ST_CLEAR,
        ST_FAULT
    } state_t;

    localparam logic [1:0] MAT_UNKNOWN = 2'd3;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_CLEAR_TO = 2'd1;
    localparam logic [1:0] FC_SORT_TO  = 2'd2;

    // Known materials map 1:1 onto bins; an unknown material goes to the
    // default bin.
    function automatic logic [1:0] material_to_bin(input logic [1:0] mat,
                                                   input logic [1:0] dflt);
        return (mat == MAT_UNKNOWN) ? dflt : mat;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// -----------------------------------------------------------------------------
// sensor_debounce
// Synchronises the asynchronous item sensor through two flops, then accepts a
// new level only after it has been stable for DEBOUNCE_CYC consecutive clocks.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   raw         raw sensor input (asynchronous)
//   level       debounced sensor level
//   rise, fall  one-cycle strobes, asserted in the cycle level changes
// -----------------------------------------------------------------------------
module sensor_debounce #(
    parameter logic [15:0] DEBOUNCE_CYC = 16'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic        sync_p0;
    logic        sync_p1;
    logic [15:0] stable_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0    <= 1'b0;
            sync_p1    <= 1'b0;
            stable_cnt <= 16'd0;
            level      <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
        end else begin
            // Synchroniser stage
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            // Debounce stage: count consecutive cycles the synchronised input
            // disagrees with the accepted level; any agreement restarts it.
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync_p1 == level) begin
                stable_cnt <= 16'd0;
            end else if (stable_cnt == DEBOUNCE_CYC - 16'd1) begin
                stable_cnt <= 16'd0;
                level      <= sync_p1;
                rise       <= sync_p1;
                fall       <= ~sync_p1;
            end else begin
                stable_cnt <= stable_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/belt_sort_sequencer.sv
// -----------------------------------------------------------------------------
// belt_sort_sequencer
// Top-level sequencer for the sorting conveyor. Runs the belt, stops it when a
// debounced item edge is seen, lets it settle, waits for a classification,
// requests the diverter for the chosen bin, then restarts the belt and waits
// for the item to clear the sensor.
// Ports:
//   clk, rst_n       clock / asynchronous active-low reset
//   start, stop      operator controls (stop has priority over everything)
//   item_present     raw item sensor, active high
//   material(_valid) classifier result and its one-cycle strobe
//   sort_done        diverter completion
//   belt_on/off      one-cycle pulses to the belt stepper
//   sort_req/bin     diverter request, held until sort_done, with bin code
//   busy             high outside IDLE and FAULT
//   fault/fault_code sticky timeout flag and its cause
//   item_count       items sorted, wrapping 16-bit count
// -----------------------------------------------------------------------------
module belt_sort_sequencer
    import sort_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYC = 16'd50000,
    parameter logic [31:0] SETTLE_CYC   = 32'd5000000,
    parameter logic [31:0] CLASSIFY_TO  = 32'd25000000,
    parameter logic [31:0] SORT_TO      = 32'd100000000,
    parameter logic [31:0] CLEAR_TO     = 32'd150000000,
    parameter logic [1:0]  DEFAULT_BIN  = 2'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        item_present,
    input  logic [1:0]  material,
    input  logic        material_valid,
    input  logic        sort_done,
    output logic        belt_on,
    output logic        belt_off,
    output logic        sort_req,
    output logic [1:0]  sort_bin,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [15:0] item_count
);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] timer;

    logic        db_level;
    logic        db_rise;
    logic        db_fall;

    logic        belt_on_nxt;
    logic        belt_off_nxt;
    logic        sort_req_nxt;
    logic [1:0]  sort_bin_nxt;
    logic        fault_nxt;
    logic [1:0]  fault_code_nxt;
    logic        count_inc;

    sensor_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (item_present),
        .level (db_level),
        .rise  (db_rise),
        .fall  (db_fall)
    );

    assign busy = (state != ST_IDLE) && (state != ST_FAULT);

    always_comb begin
        state_nxt      = state;
        belt_on_nxt    = 1'b0;
        belt_off_nxt   = 1'b0;
        sort_req_nxt   = 1'b0;
        sort_bin_nxt   = sort_bin;
        fault_nxt      = fault;
        fault_code_nxt = fault_code;
        count_inc      = 1'b0;

        if (stop) begin
            // The belt is only moving in RUN and CLEAR, so only those need an
            // explicit stop pulse.
            state_nxt      = ST_IDLE;
            belt_off_nxt   = (state == ST_RUN) || (state == ST_CLEAR);
            fault_nxt      = 1'b0;
            fault_code_nxt = FC_NONE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        belt_on_nxt = 1'b1;
                        state_nxt   = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Edge-based: an item already under the sensor when the
                    // belt starts is not taken as a new arrival.
                    if (db_rise) begin
                        belt_off_nxt = 1'b1;
                        state_nxt    = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (timer == SETTLE_CYC - 32'd1) begin
                        state_nxt = ST_CLASSIFY;
                    end
                end
                ST_CLASSIFY: begin
                    if (material_valid) begin
                        sort_bin_nxt = material_to_bin(material, DEFAULT_BIN);
                        state_nxt    = ST_SORT;
                    end else if (timer == CLASSIFY_TO - 32'd1) begin
                        sort_bin_nxt = DEFAULT_BIN;
                        state_nxt    = ST_SORT;
                    end
                end
                ST_SORT: begin
                    if (sort_done) begin
                        count_inc   = 1'b1;
                        belt_on_nxt = 1'b1;
                        state_nxt   = ST_CLEAR;
                    end else if (timer == SORT_TO - 32'd1) begin
                        fault_nxt      = 1'b1;
                        fault_code_nxt = FC_SORT_TO;
                        state_nxt      = ST_FAULT;
                    end
                end
                ST_CLEAR: begin
                    // The level test covers an item that already left before
                    // CLEAR was entered, when no fall strobe will come.
                    if (db_fall || !db_level) begin
                        state_nxt = ST_RUN;
                    end else if (timer == CLEAR_TO - 32'd1) begin
                        belt_off_nxt   = 1'b1;
                        fault_nxt      = 1'b1;
                        fault_code_nxt = FC_CLEAR_TO;
                        state_nxt      = ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    state_nxt = ST_FAULT;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        // Request is asserted from the first SORT cycle and drops as soon as
        // SORT is left for any reason.
        sort_req_nxt = (state_nxt == ST_SORT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            timer      <= 32'd0;
            belt_on    <= 1'b0;
            belt_off   <= 1'b0;
            sort_req   <= 1'b0;
            sort_bin   <= 2'd0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            item_count <= 16'd0;
        end else begin
            state      <= state_nxt;
            belt_on    <= belt_on_nxt;
            belt_off   <= belt_off_nxt;
            sort_req   <= sort_req_nxt;
            sort_bin   <= sort_bin_nxt;
            fault      <= fault_nxt;
            fault_code <= fault_code_nxt;
            // Single shared timer, restarted on every state entry and on stop.
            if (stop || (state_nxt != state)) begin
                timer <= 32'd0;
            end else begin
                timer <= timer + 32'd1;
            end
            if (count_inc) begin
                item_count <= item_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_belt_sort_sequencer.sv
module tb_belt_sort_sequencer;

    localparam int EV_ON    = 0;
    localparam int EV_OFF   = 1;
    localparam int EV_REQ   = 2;
    localparam int EV_FAULT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        item_present;
    logic [1:0]  material;
    logic        material_valid;
    logic        sort_done;
    logic        belt_on;
    logic        belt_off;
    logic        sort_req;
    logic [1:0]  sort_bin;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_code;
    logic [15:0] item_count;

    always #5 clk = ~clk;

    belt_sort_sequencer #(
        .DEBOUNCE_CYC (16'd4),
        .SETTLE_CYC   (32'd10),
        .CLASSIFY_TO  (32'd20),
        .SORT_TO      (32'd30),
        .CLEAR_TO     (32'd40),
        .DEFAULT_BIN  (2'd3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .stop           (stop),
        .item_present   (item_present),
        .material       (material),
        .material_valid (material_valid),
        .sort_done      (sort_done),
        .belt_on        (belt_on),
        .belt_off       (belt_off),
        .sort_req       (sort_req),
        .sort_bin       (sort_bin),
        .busy           (busy),
        .fault          (fault),
        .fault_code     (fault_code),
        .item_count     (item_count)
    );

    // Scoreboard: expected output events, with the required cycle gap from the
    // previously observed event (-1 when the gap is not constrained).
    typedef struct {
        int kind;
        int data;
        int gap;
    } ev_t;

    ev_t  sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_ev_cyc = 0;
    logic req_q    = 1'b0;
    logic fault_q  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input int d, input int g);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.gap  = g;
        sb_q.push_back(e);
    endtask

    task automatic observe(input int k, input int d);
        ev_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d data %0d, required no event (t=%0t)",
                     k, d, $time);
        end else begin
            e = sb_q.pop_front();
            chk("event_kind", k, e.kind);
            chk("event_data", d, e.data);
            if (e.gap >= 0) chk("event_gap", cyc - last_ev_cyc, e.gap);
        end
        last_ev_cyc = cyc;
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (belt_on) begin
                chk("on_off_exclusive", int'(belt_off), 0);
                observe(EV_ON, int'(item_count));
            end
            if (belt_off) observe(EV_OFF, 0);
            if (sort_req && !req_q) observe(EV_REQ, int'(sort_bin));
            if (fault && !fault_q) observe(EV_FAULT, int'(fault_code));
        end
        req_q   <= sort_req;
        fault_q <= fault;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        stop           = 1'b0;
        item_present   = 1'b0;
        material       = 2'd0;
        material_valid = 1'b0;
        sort_done      = 1'b0;
        step(3);

        // Reset state
        chk("rst_belt_on", int'(belt_on), 0);
        chk("rst_belt_off", int'(belt_off), 0);
        chk("rst_sort_req", int'(sort_req), 0);
        chk("rst_sort_bin", int'(sort_bin), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_fault_code", int'(fault_code), 0);
        chk("rst_item_count", int'(item_count), 0);
        rst_n = 1'b1;
        step(2);

        // Normal item, plastic; a material strobe during SETTLE must be ignored
        push(EV_ON, 0, -1);
        pulse_start();
        chk("run_busy", int'(busy), 1);
        step(3);
        push(EV_OFF, 0, -1);
        push(EV_REQ, 1, 13);
        push(EV_ON, 1, 6);
        item_present = 1'b1;
        step(8);
        item_present = 1'b0;
        step(2);
        material = 2'd0; material_valid = 1'b1;
        step(1);
        material_valid = 1'b0;
        step(8);
        material = 2'd1; material_valid = 1'b1;
        step(1);
        material_valid = 1'b0;
        step(5);
        sort_done = 1'b1;
        step(1);
        sort_done = 1'b0;
        chk("normal_sort_req_dropped", int'(sort_req), 0);
        chk("normal_item_count", int'(item_count), 1);
        step(3);
        chk("normal_back_to_run", int'(busy), 1);

        // Glitch shorter than the debounce window: no belt_off
        item_present = 1'b1;
        step(2);
        item_present = 1'b0;
        step(15);
        chk("glitch_still_running", int'(busy), 1);

        // Classify timeout: default bin exactly 20 clk after CLASSIFY entry
        push(EV_OFF, 0, -1);
        push(EV_REQ, 3, 30);
        push(EV_ON, 2, 4);
        item_present = 1'b1;
        step(8);
        item_present = 1'b0;
        step(28);
        chk("cls_to_not_yet", int'(sort_req), 0);
        step(1);
        chk("cls_to_sort_req", int'(sort_req), 1);
        chk("cls_to_bin", int'(sort_bin), 3);
        chk("cls_to_no_fault", int'(fault), 0);
        step(3);
        sort_done = 1'b1;
        step(1);
        sort_done = 1'b0;
        chk("cls_to_item_count", int'(item_count), 2);
        step(3);

        // Sort timeout, with unknown material mapped to the default bin
        push(EV_OFF, 0, -1);
        push(EV_REQ, 3, 13);
        push(EV_FAULT, 2, 30);
        item_present = 1'b1;
        step(8);
        item_present = 1'b0;
        step(11);
        material = 2'd3; material_valid = 1'b1;
        step(1);
        material_valid = 1'b0;
        step(29);
        chk("sort_to_not_yet", int'(fault), 0);
        step(1);
        chk("sort_to_fault", int'(fault), 1);
        chk("sort_to_code", int'(fault_code), 2);
        chk("sort_to_req_low", int'(sort_req), 0);
        chk("sort_to_not_busy", int'(busy), 0);
        pulse_start();
        step(5);
        chk("fault_ignores_start", int'(fault), 1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("stop_clears_fault", int'(fault), 0);
        chk("stop_clears_code", int'(fault_code), 0);
        chk("stop_to_idle", int'(busy), 0);

        // Clear timeout: sensor never drops after restart
        push(EV_ON, 2, -1);
        pulse_start();
        step(3);
        push(EV_OFF, 0, -1);
        push(EV_REQ, 1, 13);
        push(EV_ON, 3, 2);
        push(EV_OFF, 0, 40);
        push(EV_FAULT, 1, 0);
        item_present = 1'b1;
        step(8);
        step(11);
        material = 2'd1; material_valid = 1'b1;
        step(1);
        material_valid = 1'b0;
        step(1);
        sort_done = 1'b1;
        step(1);
        sort_done = 1'b0;
        step(39);
        chk("clear_to_not_yet", int'(fault), 0);
        step(1);
        chk("clear_to_fault", int'(fault), 1);
        chk("clear_to_code", int'(fault_code), 1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;

        // Item already present at start is not detected; a fresh edge is.
        // Then stop mid-SETTLE: no pulse, back to IDLE.
        push(EV_ON, 3, -1);
        pulse_start();
        step(10);
        chk("present_at_start_running", int'(busy), 1);
        item_present = 1'b0;
        step(10);
        push(EV_OFF, 0, -1);
        item_present = 1'b1;
        step(8);
        item_present = 1'b0;
        step(2);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("stop_settle_idle", int'(busy), 0);
        chk("stop_settle_req", int'(sort_req), 0);
        step(30);

        // start and stop together in IDLE: stop wins
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        step(3);
        chk("start_stop_idle", int'(busy), 0);

        // Stop held for several cycles in RUN: exactly one belt_off
        push(EV_ON, 3, -1);
        pulse_start();
        step(3);
        push(EV_OFF, 0, 4);
        stop = 1'b1;
        step(3);
        stop = 1'b0;
        step(3);
        chk("stop_run_idle", int'(busy), 0);

        // Asynchronous reset while in SORT
        push(EV_ON, 3, -1);
        pulse_start();
        step(3);
        push(EV_OFF, 0, -1);
        push(EV_REQ, 2, 13);
        item_present = 1'b1;
        step(8);
        item_present = 1'b0;
        step(11);
        material = 2'd2; material_valid = 1'b1;
        step(1);
        material_valid = 1'b0;
        step(3);
        chk("pre_reset_sort_req", int'(sort_req), 1);
        chk("pre_reset_item_count", int'(item_count), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sort_req", int'(sort_req), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_item_count", int'(item_count), 0);
        step(2);
        rst_n = 1'b1;
        step(3);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
